// File: rtl/pa_ifu_spsram_pkg.sv
// Shared types and defaults for the IFU single-port SRAM access controller.
package pa_ifu_spsram_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 47;
  localparam logic [DATA_WIDTH_DEF-1:0] INV_DATA_DEF = '0;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_INV  = 2'b10
  } spsram_state_e;

endpackage

// File: rtl/pa_ifu_spsram_ctrl_if.sv
// Requester and SRAM-pin bundle of the IFU SRAM controller; slave = controller side.
interface pa_ifu_spsram_ctrl_if
  import pa_ifu_spsram_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  inv_req;
  logic                  inv_busy;
  logic                  inv_done;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_gnt;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_cen;
  logic                  ram_gwen;
  logic [DATA_WIDTH-1:0] ram_wen;
  logic [DATA_WIDTH-1:0] ram_d;
  logic [DATA_WIDTH-1:0] ram_q;

  modport slave (
    input  inv_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, ram_q,
    output inv_busy, inv_done, rd_gnt, rd_vld, rd_data, wr_gnt,
           ram_a, ram_cen, ram_gwen, ram_wen, ram_d
  );

  modport master (
    output inv_req, rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, ram_q,
    input  inv_busy, inv_done, rd_gnt, rd_vld, rd_data, wr_gnt,
           ram_a, ram_cen, ram_gwen, ram_wen, ram_d
  );
endinterface

// File: rtl/pa_ifu_spsram_arb.sv
// IDLE-state read/write arbiter: write wins unless the read has been denied STARVE_LIMIT times in a row.
module pa_ifu_spsram_arb #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic forever_cpuclk,
  input  logic cpurst_b,
  input  logic en,
  input  logic rd_req,
  input  logic wr_req,
  output logic rd_gnt,
  output logic wr_gnt
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt;
  logic          rd_promote;

  assign rd_promote = (starve_cnt == LIM);
  assign wr_gnt     = en && wr_req && !(rd_req && rd_promote);
  assign rd_gnt     = en && rd_req && !wr_gnt;

  // Counter only moves while arbitration is live; invalidate cycles leave it untouched.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      starve_cnt <= '0;
    end else if (en) begin
      if (rd_req && wr_gnt) begin
        if (starve_cnt != LIM) starve_cnt <= starve_cnt + CW'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/pa_ifu_spsram_ctrl.sv
// IFU 32x47 single-port SRAM controller: invalidate walk after reset/request, then read/write arbitration.
module pa_ifu_spsram_ctrl
  import pa_ifu_spsram_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] INV_DATA     = DATA_WIDTH'(INV_DATA_DEF),
  parameter int                    STARVE_LIMIT = 2
) (
  input logic                  forever_cpuclk,
  input logic                  cpurst_b,
  pa_ifu_spsram_ctrl_if.slave  bus
);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  spsram_state_e         state;
  logic [ADDR_WIDTH-1:0] inv_cnt;
  logic                  inv_done_q;
  logic                  rd_vld_q;
  logic                  arb_en;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic [ADDR_WIDTH-1:0] a_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic                  cen_c;
  logic                  gwen_c;
  logic [ADDR_WIDTH-1:0] a_c;
  logic [DATA_WIDTH-1:0] d_c;
  logic [DATA_WIDTH-1:0] wen_c;

  // A pending invalidate request suppresses user grants in the cycle it is seen.
  assign arb_en = (state == ST_IDLE) && !bus.inv_req;

  pa_ifu_spsram_arb #(.STARVE_LIMIT(STARVE_LIMIT)) u_arb (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .en             (arb_en),
    .rd_req         (bus.rd_req),
    .wr_req         (bus.wr_req),
    .rd_gnt         (rd_gnt),
    .wr_gnt         (wr_gnt)
  );

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state      <= ST_INIT;
      inv_cnt    <= '0;
      inv_done_q <= 1'b0;
      rd_vld_q   <= 1'b0;
    end else begin
      rd_vld_q   <= rd_gnt;
      inv_done_q <= 1'b0;
      unique case (state)
        ST_INIT: begin
          state   <= ST_INV;
          inv_cnt <= '0;
        end
        ST_IDLE: begin
          if (bus.inv_req) begin
            state   <= ST_INV;
            inv_cnt <= '0;
          end
        end
        ST_INV: begin
          // A fresh request restarts the walk so every entry is cleared after it.
          if (bus.inv_req) begin
            inv_cnt <= '0;
          end else begin
            inv_cnt <= inv_cnt + ADDR_WIDTH'(1);
            if (inv_cnt == LAST_ADDR) begin
              state      <= ST_IDLE;
              inv_done_q <= 1'b1;
            end
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  always_comb begin
    cen_c  = 1'b1;
    gwen_c = 1'b1;
    wen_c  = '1;
    a_c    = a_hold;
    d_c    = d_hold;
    if (state == ST_INV) begin
      cen_c  = 1'b0;
      gwen_c = 1'b0;
      wen_c  = '0;
      a_c    = inv_cnt;
      d_c    = INV_DATA;
    end else if (wr_gnt) begin
      cen_c  = 1'b0;
      gwen_c = 1'b0;
      wen_c  = ~bus.wr_mask;
      a_c    = bus.wr_addr;
      d_c    = bus.wr_data;
    end else if (rd_gnt) begin
      cen_c  = 1'b0;
      a_c    = bus.rd_addr;
    end
  end

  // Address/data pins keep their last driven value on idle cycles to avoid toggling.
  always_ff @(posedge forever_cpuclk) begin
    if (!cen_c) begin
      a_hold <= a_c;
      d_hold <= d_c;
    end
  end

  assign bus.ram_cen  = cen_c;
  assign bus.ram_gwen = gwen_c;
  assign bus.ram_wen  = wen_c;
  assign bus.ram_a    = a_c;
  assign bus.ram_d    = d_c;
  assign bus.rd_gnt   = rd_gnt;
  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_data  = bus.ram_q;
  assign bus.inv_busy = (state != ST_IDLE);
  assign bus.inv_done = inv_done_q;
endmodule

// File: tb/tb_pa_ifu_spsram_ctrl.sv
// Directed + random bench for pa_ifu_spsram_ctrl with an SRAM model and a contents/arbitration reference.
module tb_pa_ifu_spsram_ctrl;
  localparam int LIMIT = 2;
  localparam logic [46:0] ALL1 = '1;
  localparam logic [46:0] ALL0 = '0;

  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_err = 0;

  pa_ifu_spsram_ctrl_if bus ();

  pa_ifu_spsram_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // Behavioural single-port SRAM: registered read, bit-masked write.
  logic [46:0] sram [32];
  always @(posedge clk) begin
    if (!bus.ram_cen) begin
      if (!bus.ram_gwen)
        sram[bus.ram_a] <= (sram[bus.ram_a] & bus.ram_wen) | (bus.ram_d & ~bus.ram_wen);
      else
        bus.ram_q <= sram[bus.ram_a];
    end
  end

  // Reference state: expected contents, consecutive write-denials of the read, outstanding read.
  logic [46:0] ref_mem [32];
  int          den;
  logic        pend_vld;
  logic [46:0] pend_data;
  logic [4:0]  last_a;
  logic [46:0] last_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic rr, input logic [4:0] ra, input logic wr,
                       input logic [4:0] wa, input logic [46:0] wd, input logic [46:0] wm);
    logic we, re;
    logic [46:0] nwm;
    bus.rd_req  = rr;
    bus.rd_addr = ra;
    bus.wr_req  = wr;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_mask = wm;
    we  = wr && !(rr && den == LIMIT);
    re  = rr && !we;
    nwm = ~wm;
    @(negedge clk);
    chk("wr_gnt", bus.wr_gnt, we);
    chk("rd_gnt", bus.rd_gnt, re);
    chk("rd_vld", bus.rd_vld, pend_vld);
    chk("inv_busy_idle", bus.inv_busy, 1'b0);
    chk("inv_done_idle", bus.inv_done, 1'b0);
    if (pend_vld) chk("rd_data", bus.rd_data, pend_data);
    if (we) begin
      chk("wr_cen", bus.ram_cen, 1'b0);
      chk("wr_gwen", bus.ram_gwen, 1'b0);
      chk("wr_a", bus.ram_a, wa);
      chk("wr_d", bus.ram_d, wd);
      chk("wr_wen", bus.ram_wen, nwm);
      ref_mem[wa] = (ref_mem[wa] & ~wm) | (wd & wm);
      last_a = wa;
      last_d = wd;
    end else if (re) begin
      chk("rd_cen", bus.ram_cen, 1'b0);
      chk("rd_gwen", bus.ram_gwen, 1'b1);
      chk("rd_a", bus.ram_a, ra);
      chk("rd_wen", bus.ram_wen, ALL1);
      last_a = ra;
    end else begin
      chk("nop_cen", bus.ram_cen, 1'b1);
      chk("nop_gwen", bus.ram_gwen, 1'b1);
      chk("nop_wen", bus.ram_wen, ALL1);
      chk("hold_a", bus.ram_a, last_a);
      chk("hold_d", bus.ram_d, last_d);
    end
    pend_vld = re;
    if (re) pend_data = ref_mem[ra];
    if (rr && we) den = (den < LIMIT) ? den + 1 : den;
    else          den = 0;
    @(posedge clk); #1;
  endtask

  task automatic walk_step(input logic [4:0] exp_a);
    @(negedge clk);
    chk("inv_cen", bus.ram_cen, 1'b0);
    chk("inv_gwen", bus.ram_gwen, 1'b0);
    chk("inv_wen", bus.ram_wen, ALL0);
    chk("inv_a", bus.ram_a, exp_a);
    chk("inv_d", bus.ram_d, ALL0);
    chk("inv_busy", bus.inv_busy, 1'b1);
    chk("inv_done_walk", bus.inv_done, 1'b0);
    chk("inv_no_rd_gnt", bus.rd_gnt, 1'b0);
    chk("inv_no_wr_gnt", bus.wr_gnt, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) sram[i] <= 47'({$urandom(), $urandom()});
    rst_b = 1'b0;
    bus.inv_req = 1'b0;
    bus.rd_req = 1'b0;  bus.rd_addr = '0;
    bus.wr_req = 1'b0;  bus.wr_addr = '0;
    bus.wr_data = '0;   bus.wr_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", bus.inv_busy, 1'b1);
    chk("rst_vld", bus.rd_vld, 1'b0);
    chk("rst_cen", bus.ram_cen, 1'b1);
    chk("rst_done", bus.inv_done, 1'b0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // One INIT cycle, then the 32-entry clear.
    @(negedge clk);
    chk("init_cen", bus.ram_cen, 1'b1);
    chk("init_gwen", bus.ram_gwen, 1'b1);
    chk("init_wen", bus.ram_wen, ALL1);
    chk("init_busy", bus.inv_busy, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) walk_step(5'(i));
    @(negedge clk);
    chk("done_pulse", bus.inv_done, 1'b1);
    chk("done_busy", bus.inv_busy, 1'b0);
    chk("done_cen", bus.ram_cen, 1'b1);
    @(posedge clk); #1;
    clear_ref();
    den = 0; pend_vld = 1'b0; pend_data = '0; last_a = 5'd31; last_d = '0;

    // Full write then read back, then partial-mask merge.
    cycle(1'b0, 5'd0, 1'b1, 5'd5, 47'h1234, ALL1);
    cycle(1'b1, 5'd5, 1'b0, 5'd0, '0, '0);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, '0, '0);
    cycle(1'b0, 5'd0, 1'b1, 5'd9, 47'h7FFF_FFFF_FFFF, ALL1);
    cycle(1'b0, 5'd0, 1'b1, 5'd9, '0, 47'hFF);
    cycle(1'b1, 5'd9, 1'b0, 5'd0, '0, '0);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, '0, '0);
    chk("partial_mask_ref", ref_mem[9], 47'h7FFF_FFFF_FF00);
    cycle(1'b1, 5'd0, 1'b0, 5'd0, '0, '0);

    // Continuous read+write contention exercises the starvation promotion.
    for (int i = 0; i < 7; i++)
      cycle(1'b1, 5'd4, 1'b1, 5'(i), 47'({$urandom(), $urandom()}), ALL1);
    cycle(1'b0, 5'd0, 1'b0, 5'd0, '0, '0);

    for (int i = 0; i < 300; i++) begin
      logic [46:0] m;
      m = ($urandom_range(0, 3) == 0) ? ALL1 : 47'({$urandom(), $urandom()});
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            47'({$urandom(), $urandom()}), m);
    end
    cycle(1'b0, 5'd0, 1'b0, 5'd0, '0, '0);

    // Invalidate request in IDLE with both requesters active, restart mid-walk at entry 10.
    bus.inv_req = 1'b1;
    bus.rd_req = 1'b1; bus.rd_addr = 5'd7;
    bus.wr_req = 1'b1; bus.wr_addr = 5'd3;
    @(negedge clk);
    chk("invreq_rd_gnt", bus.rd_gnt, 1'b0);
    chk("invreq_wr_gnt", bus.wr_gnt, 1'b0);
    chk("invreq_cen", bus.ram_cen, 1'b1);
    chk("invreq_vld", bus.rd_vld, 1'b0);
    @(posedge clk); #1;
    bus.inv_req = 1'b0;
    bus.wr_req = 1'b0;
    for (int i = 0; i < 10; i++) walk_step(5'(i));
    bus.inv_req = 1'b1;
    walk_step(5'd10);
    bus.inv_req = 1'b0;
    for (int i = 0; i < 32; i++) walk_step(5'(i));
    clear_ref();
    @(negedge clk);
    chk("redo_done", bus.inv_done, 1'b1);
    chk("held_rd_gnt", bus.rd_gnt, 1'b1);
    chk("held_rd_a", bus.ram_a, 5'd7);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("held_rd_vld", bus.rd_vld, 1'b1);
    chk("held_rd_data", bus.rd_data, ref_mem[7]);
    chk("redo_done_once", bus.inv_done, 1'b0);
    @(posedge clk); #1;

    // Reset landing on a read grant.
    bus.rd_req = 1'b1; bus.rd_addr = 5'd2;
    @(negedge clk);
    chk("pre_rst_rd_gnt", bus.rd_gnt, 1'b1);
    #1 rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", bus.rd_vld, 1'b0);
    chk("mid_rst_busy", bus.inv_busy, 1'b1);
    chk("mid_rst_cen", bus.ram_cen, 1'b1);
    @(posedge clk); #1;
    walk_step(5'd0);
    walk_step(5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pa_ifu_spsram_ctrl.md
Name: pa_ifu_spsram_ctrl

Overview:
- Access controller and arbiter for the IFU 32-entry x 47-bit single-port SRAM.
- Shares the one physical port between three sources: a lookup read requester, a refill/update write requester, and an internal invalidate sequencer.
- The sequencer clears every entry after reset and on request.
- Drives the active-low SRAM controls (chip enable, global write enable, per-bit write enable) and returns read data with a valid strobe.

Parameters:
ADDR_WIDTH, 5, SRAM address width (depth = 2^ADDR_WIDTH = 32)
DATA_WIDTH, 47, SRAM data width
INV_DATA, 47'b0, value written to every entry during invalidate
STARVE_LIMIT, 2, consecutive write-induced read denials before the read is promoted over the write

Ports:
forever_cpuclk  input  1  clock
cpurst_b  input  1  synchronous active-low reset
inv_req  input  1  request to invalidate all entries (level, sampled each cycle)
inv_busy  output  1  invalidate walk in progress (INIT or INV state)
inv_done  output  1  one-cycle pulse after the last invalidate write
rd_req  input  1  read request
rd_addr  input  ADDR_WIDTH  read address
rd_gnt  output  1  read accepted this cycle
rd_vld  output  1  read data valid (cycle after rd_gnt)
rd_data  output  DATA_WIDTH  read data
wr_req  input  1  write request
wr_addr  input  ADDR_WIDTH  write address
wr_data  input  DATA_WIDTH  write data
wr_mask  input  DATA_WIDTH  per-bit write enable, 1 = write bit
wr_gnt  output  1  write accepted this cycle
ram_a  output  ADDR_WIDTH  SRAM address
ram_cen  output  1  SRAM chip enable, active low
ram_gwen  output  1  SRAM global write enable, active low
ram_wen  output  DATA_WIDTH  SRAM per-bit write enable, active low
ram_d  output  DATA_WIDTH  SRAM write data
ram_q  input  DATA_WIDTH  SRAM read data (valid one cycle after read access)

Behaviour:
- Clocking and reset: one clock, forever_cpuclk. Reset cpurst_b is synchronous and active-low. All flops reset only on a clock edge with cpurst_b=0.
- FSM states: INIT, IDLE, INV. Reset value is INIT, inv_cnt=0, starve_cnt=0, rd_vld=0.
- INIT: no SRAM access (ram_cen=1, ram_gwen=1, ram_wen=all 1); inv_busy=1; goes unconditionally to INV next cycle.
- INV walk: each cycle writes INV_DATA to address inv_cnt with ram_cen=0, ram_gwen=0, ram_wen=all 0; inv_cnt increments.
- End of walk: after the write at inv_cnt=31, go to IDLE and pulse inv_done in the first IDLE cycle. inv_cnt returns to 0 (5-bit wrap).
- inv_req asserted during INV: inv_cnt restarts at 0 next cycle, so every entry is written after the latest request. inv_done is not pulsed for the aborted walk.
- inv_req in IDLE: enter INV next cycle. No user grant is issued in the cycle inv_req is seen.
- During INIT/INV: rd_gnt=0 and wr_gnt=0. Requesters hold their requests.
- IDLE arbitration, at most one access per cycle:
  - Default priority is write > read.
  - If starve_cnt == STARVE_LIMIT and rd_req=1, the read wins over a pending write.
  - starve_cnt increments when rd_req=1 and the read is denied because of a write; it clears on rd_gnt or when rd_req=0; it saturates at STARVE_LIMIT.
- Read grant: ram_cen=0, ram_gwen=1, ram_wen=all 1, ram_a=rd_addr. rd_vld=1 the following cycle, rd_data=ram_q (combinational pass-through). rd_data is don't-care when rd_vld=0.
- Write grant: ram_cen=0, ram_gwen=0, ram_a=wr_addr, ram_d=wr_data, ram_wen=~wr_mask.
- No access: ram_cen=1, ram_gwen=1, ram_wen=all 1. ram_a and ram_d hold their last driven values to avoid toggling.
- Grants are combinational from request and state; the requester may drop the request in the cycle after a grant.
- Write followed by read of the same address in the next cycle returns the new data. No internal bypass is needed because accesses are serialized.
- Reset mid-walk or mid-read: returns to INIT, rd_vld=0 next cycle, and the walk fully restarts.

Decomposition:
- Shared package pa_ifu_spsram_pkg: FSM state encoding (INIT=2'b00, IDLE=2'b01, INV=2'b10), ADDR_WIDTH/DATA_WIDTH defaults, INV_DATA.
- One natural sub-module, pa_ifu_spsram_arb: the IDLE read/write arbiter with starvation counter.
- Top level holds the FSM, invalidate counter, and SRAM control muxing.

Test Plan:
- Reset release -> 1 INIT cycle, then 32 writes of 0 at addresses 0..31 with ram_gwen=0; inv_done pulses in cycle 34 after release; inv_busy=1 throughout.
- IDLE: write addr 5 data 47'h1234 mask all 1s, then read addr 5 -> rd_vld one cycle after rd_gnt, rd_data=47'h1234.
- Partial mask: write 47'h7FFF_FFFF_FFFF, then write 0 with mask 47'hFF -> read returns 47'h7FFF_FFFF_FF00.
- Continuous wr_req plus rd_req (STARVE_LIMIT=2) -> wr_gnt, wr_gnt, then rd_gnt in cycle 3; pattern repeats.
- inv_req at inv_cnt=10 during INV -> ram_a returns to 0 next cycle; 32 more writes follow; exactly one inv_done pulse.
- rd_req held during INV -> rd_gnt=0 until the first IDLE cycle, then granted; the read returns INV_DATA.
